// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load write-back requests onto one register-file write port.
// Each requester has its own FIFO. A round-robin arbiter drains them, and decode gets pending-write hazard flags.
module regfile_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_data,
  output logic        rWrite,
  output logic [4:0]  rsWrite,
  output logic [31:0] dataWrite,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        pend_rs1,
  output logic        pend_rs2,
  output logic        idle
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REQ_A = 0;
  localparam int REQ_M = 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t           r_mem  [2][DEPTH];
  logic [PTR_W-1:0] r_rptr [2];
  logic [PTR_W-1:0] r_wptr [2];
  logic [CNT_W-1:0] r_cnt  [2];
  logic             r_last_m;
  logic             r_rst_n;

  entry_t     w_in   [2];
  entry_t     w_head [2];
  entry_t     w_issue;
  logic [1:0] w_valid;
  logic [1:0] w_ready;
  logic [1:0] w_push;
  logic [1:0] w_hv;
  logic [1:0] w_grant;
  logic       w_grant_a;
  logic       w_grant_m;

  assign w_in[REQ_A] = '{rd: a_rd, data: a_data};
  assign w_in[REQ_M] = '{rd: m_rd, data: m_data};
  assign w_valid     = {m_valid, a_valid};

  // Reset release is retimed to clk; pushes stay blocked until the cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_n <= 1'b0;
    else        r_rst_n <= 1'b1;
  end

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      w_ready[q] = r_cnt[q] < CNT_W'(DEPTH);
      w_push[q]  = w_valid[q] & w_ready[q] & r_rst_n;
      w_hv[q]    = r_cnt[q] != '0;
      w_head[q]  = r_mem[q][r_rptr[q]];
    end
  end

  assign a_ready = w_ready[REQ_A];
  assign m_ready = w_ready[REQ_M];

  // Round-robin: on contention the requester that did not win last time goes.
  assign w_grant_a = w_hv[REQ_A] & (~w_hv[REQ_M] | r_last_m);
  assign w_grant_m = w_hv[REQ_M] & ~w_grant_a;
  assign w_grant   = {w_grant_m, w_grant_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < 2; q++) begin
        r_rptr[q] <= '0;
        r_wptr[q] <= '0;
        r_cnt[q]  <= '0;
      end
      r_last_m <= 1'b1;
    end else begin
      for (int q = 0; q < 2; q++) begin
        r_wptr[q] <= r_wptr[q] + PTR_W'(w_push[q]);
        r_rptr[q] <= r_rptr[q] + PTR_W'(w_grant[q]);
        r_cnt[q]  <= r_cnt[q] + CNT_W'(w_push[q]) - CNT_W'(w_grant[q]);
      end
      if (w_grant_a | w_grant_m) r_last_m <= w_grant_m;
    end
  end

  always_ff @(posedge clk) begin
    for (int q = 0; q < 2; q++) begin
      if (w_push[q]) r_mem[q][r_wptr[q]] <= w_in[q];
    end
  end

  // A granted rd==0 entry is still popped, but it never reaches the write port.
  assign w_issue   = w_grant_a ? w_head[REQ_A] : w_head[REQ_M];
  assign rWrite    = (w_grant_a | w_grant_m) & (w_issue.rd != 5'd0);
  assign rsWrite   = rWrite ? w_issue.rd : 5'd0;
  assign dataWrite = rWrite ? w_issue.data : 32'd0;
  assign idle      = ~w_hv[REQ_A] & ~w_hv[REQ_M];

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    pend_rs1 = 1'b0;
    pend_rs2 = 1'b0;
    for (int q = 0; q < 2; q++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = r_rptr[q] + PTR_W'(k);
        if (CNT_W'(k) < r_cnt[q]) begin
          if (r_mem[q][idx].rd == rs1) pend_rs1 = 1'b1;
          if (r_mem[q][idx].rd == rs2) pend_rs2 = 1'b1;
        end
      end
    end
    if (rs1 == 5'd0) pend_rs1 = 1'b0;
    if (rs2 == 5'd0) pend_rs2 = 1'b0;
  end

endmodule
